// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/cmp/shl/pass in one pass, mul/div/mod iterate one bit per cycle.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, N+1 cycles for mul/div/mod.
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready, no skid.
module alu_seq #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   aluControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] resultado,
    output logic         cout,
    output logic         zero,
    output logic         neg,
    output logic         overflow,
    output logic         busy
);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
                           OP_MOD = 3'b100, OP_SHL = 3'b101, OP_PAS = 3'b110, OP_CMP = 3'b111;
    localparam logic [SHW-1:0] CNT_INIT = SHW'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic [N:0]     hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   res_q, res_d;
    logic           cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

    logic [N:0]     add_s, sub_s, mul_sum, mul_hi, rem_sh, trial, div_hi;
    logic [N-1:0]   mul_lo, div_lo;
    logic           load;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        add_s = {1'b0, a} + {1'b0, b};
        sub_s = {1'b0, a} - {1'b0, b};

        // Multiply: {hi,lo} holds partial product over the multiplier, shifted right each step.
        mul_sum = lo_q[0] ? hi_q + {1'b0, opnd_q} : hi_q;
        mul_hi  = {1'b0, mul_sum[N:1]};
        mul_lo  = {mul_sum[0], lo_q[N-1:1]};

        // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        rem_sh = {hi_q[N-1:0], lo_q[N-1]};
        trial  = rem_sh - {1'b0, opnd_q};
        if (!trial[N]) begin
            div_hi = trial;
            div_lo = {lo_q[N-2:0], 1'b1};
        end else begin
            div_hi = rem_sh;
            div_lo = {lo_q[N-2:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = aluControl;
                    cnt_d  = CNT_INIT;
                    hi_d   = '0;
                    cout_d = 1'b0;
                    neg_d  = 1'b0;
                    ovf_d  = 1'b0;
                    state_d = DONE;
                    case (aluControl)
                        OP_ADD: begin
                            res_d  = add_s[N-1:0];
                            cout_d = add_s[N];
                            neg_d  = add_s[N-1];
                            ovf_d  = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
                            load   = 1'b1;
                        end
                        OP_SUB, OP_CMP: begin
                            res_d  = sub_s[N-1:0];
                            cout_d = ~sub_s[N];
                            neg_d  = sub_s[N-1];
                            ovf_d  = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
                            load   = 1'b1;
                        end
                        OP_SHL: begin
                            res_d = a << b[SHW-1:0];
                            load  = 1'b1;
                        end
                        OP_PAS: begin
                            res_d = b;
                            load  = 1'b1;
                        end
                        OP_MUL: begin
                            opnd_d  = a;
                            lo_d    = b;
                            state_d = MUL;
                        end
                        default: begin
                            if (b == '0) begin
                                res_d = (aluControl == OP_DIV) ? '1 : a;
                                ovf_d = 1'b1;
                                load  = 1'b1;
                            end else begin
                                opnd_d  = b;
                                lo_d    = a;
                                state_d = DIV;
                            end
                        end
                    endcase
                end
            end
            MUL: begin
                hi_d = mul_hi;
                lo_d = mul_lo;
                if (cnt_q == '0) begin
                    res_d   = mul_lo;
                    cout_d  = |mul_hi;
                    ovf_d   = |mul_hi;
                    load    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            DIV: begin
                hi_d = div_hi;
                lo_d = div_lo;
                if (cnt_q == '0) begin
                    res_d   = (op_q == OP_MOD) ? div_hi[N-1:0] : div_lo;
                    load    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase

        if (load) zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign resultado = res_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at N=32 and N=8 with an expected-result queue.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32, co32, z32, n32, of32, bz32;
    logic [31:0] a32, b32, r32;
    logic [2:0]  op32;
    logic        iv8, ir8, ov8, or8, co8, z8, n8, of8, bz8;
    logic [7:0]  a8, b8, r8;
    logic [2:0]  op8;

    alu_seq #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .aluControl(op32), .out_valid(ov32), .out_ready(or32), .resultado(r32),
        .cout(co32), .zero(z32), .neg(n32), .overflow(of32), .busy(bz32)
    );

    alu_seq #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .aluControl(op8), .out_valid(ov8), .out_ready(or8), .resultado(r8),
        .cout(co8), .zero(z8), .neg(n8), .overflow(of8), .busy(bz8)
    );

    typedef struct {
        logic [31:0] res;
        logic        cout, zero, neg, ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit w8, input string tag, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv, input logic [31:0] er,
                          input logic ec, input logic ez, input logic en, input logic eo,
                          input int el);
        exp_t e;
        int   lat;
        e.res = er; e.cout = ec; e.zero = ez; e.neg = en; e.ovf = eo; e.lat = el;
        sb.push_back(e);
        @(negedge clk);
        check({tag, " in_ready"}, w8 ? ir8 : ir32, 1);
        if (w8) begin iv8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; op8 = op; end
        else begin iv32 = 1'b1; a32 = av; b32 = bv; op32 = op; end
        @(posedge clk);
        #1;
        // Operands and op scrambled right after accept must not disturb the running op.
        iv32 = 1'b0; iv8 = 1'b0;
        a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
        lat = 1;
        while (!(w8 ? ov8 : ov32) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " out_valid"}, w8 ? ov8 : ov32, 1);
        e = sb.pop_front();
        check({tag, " latency"}, lat, e.lat);
        check({tag, " resultado"}, w8 ? {24'd0, r8} : r32, e.res);
        check({tag, " flags c/z/n/v"}, w8 ? {co8, z8, n8, of8} : {co32, z32, n32, of32},
              {e.cout, e.zero, e.neg, e.ovf});
        @(posedge clk);
    endtask

    initial begin
        int seen;
        exp_t e;
        rst_n = 1'b0;
        iv32 = 0; a32 = 0; b32 = 0; op32 = 0; or32 = 1;
        iv8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 1;
        #12;
        check("reset in_ready", ir32, 1);
        check("reset out_valid/busy", {ov32, bz32}, 0);
        check("reset resultado+flags", {r32, co32, z32, n32, of32}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, "add ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 1, 1);
        run_op(0, "sub 5-5", 3'b001, 5, 5, 0, 1, 1, 0, 0, 1);
        run_op(0, "sub 3-5", 3'b001, 3, 5, 32'hFFFF_FFFE, 0, 0, 1, 0, 1);
        run_op(0, "cmp min-1", 3'b111, 32'h8000_0000, 1, 32'h7FFF_FFFF, 1, 0, 0, 1, 1);
        run_op(0, "mul 2^16sq", 3'b010, 32'h1_0000, 32'h1_0000, 0, 1, 1, 0, 1, 33);
        run_op(0, "mul 12x11", 3'b010, 12, 11, 132, 0, 0, 0, 0, 33);
        run_op(0, "mul max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 33);
        run_op(0, "div 100/7", 3'b011, 100, 7, 14, 0, 0, 0, 0, 33);
        run_op(0, "mod 100/7", 3'b100, 100, 7, 2, 0, 0, 0, 0, 33);
        run_op(0, "div max/1", 3'b011, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 33);
        run_op(0, "mod 7/9", 3'b100, 7, 9, 7, 0, 0, 0, 0, 33);
        run_op(0, "div 5/0", 3'b011, 5, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1);
        run_op(0, "mod 5/0", 3'b100, 5, 0, 5, 0, 0, 0, 1, 1);
        run_op(0, "pass 0", 3'b110, 123, 0, 0, 0, 1, 0, 0, 1);
        run_op(0, "shl 3<<33", 3'b101, 3, 33, 6, 0, 0, 0, 0, 1);
        run_op(1, "n8 add", 3'b000, 8'hFF, 8'h01, 0, 1, 1, 0, 0, 1);
        run_op(1, "n8 mul", 3'b010, 16, 16, 0, 1, 1, 0, 1, 9);
        run_op(1, "n8 div", 3'b011, 200, 3, 66, 0, 0, 0, 0, 9);

        // Backpressure: result held through a 10-cycle stall.
        or32 = 1'b0;
        e.res = 16; e.cout = 0; e.zero = 0; e.neg = 0; e.ovf = 0; e.lat = 1;
        sb.push_back(e);
        @(negedge clk);
        iv32 = 1'b1; a32 = 1; b32 = 4; op32 = 3'b101;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        check("bp out_valid", ov32, 1);
        e = sb.pop_front();
        check("bp resultado", r32, e.res);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
            @(posedge clk);
            #1;
            check("bp stall hold", {r32, ov32, ir32}, {e.res, 1'b1, 1'b0});
        end
        @(negedge clk);
        or32 = 1'b1;
        @(posedge clk);
        #1;
        check("bp release", {ov32, ir32}, 2'b01);

        // Reset in the middle of a multiply drops it.
        @(negedge clk);
        iv32 = 1'b1; a32 = 7; b32 = 9; op32 = 3'b010;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst mid busy", {bz32, ir32}, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst mid outputs", {ov32, bz32, ir32, co32, z32, n32, of32}, 7'b0010000);
        check("rst mid resultado", r32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov32) seen++;
        end
        check("rst no late out_valid", seen, 0);
        run_op(0, "post-rst add", 3'b000, 40, 2, 42, 0, 0, 0, 0, 1);

        check("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
